uart_rx_fifo: RTL and testbench

- UART receiver for the serial line driven by the team's UART transmitter.
- Samples the asynchronous `rx` pin at 16x the bit rate and uses a majority vote per bit.
- Checks framing, then queues received bytes in a small FIFO.
- A host reads the queue through a `ready`/`rd_en` handshake.

---
 rtl/uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchronizer, 16x oversampling with 3-sample majority vote,
// framing check and a small byte FIFO. Optional even parity via UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int SAMPLE_DIV = 54,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    data_out,
  output logic                          ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] TICK_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a low level on rxs
  // S_START  | start bit; sample 7 must still be low
  // S_DATA   | eight data bits, LSB first, majority of samples 7/8/9
  // S_PARITY | parity bit (only with UART_RX_PARITY_EN)
  // S_STOP   | stop bit checked at sample 7
  // S_BREAK  | stop bit was low; wait for the line to go high
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_next;

  logic rx_meta, rxs;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [3:0]  samp_idx;
  logic [2:0]  bit_idx;
  logic        s7, s8;
  logic        vote_bit;
  logic [7:0]  shreg;
  logic        par_bad;

  logic clr_timer, bit_clr, bit_inc, shift_en, push_req, set_ferr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, do_push, drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr_timer) begin
      tick_cnt <= '0;
      samp_idx <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      samp_idx <= samp_idx + 4'd1;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s7 <= 1'b1;
      s8 <= 1'b1;
    end else if (tick) begin
      if (samp_idx == 4'd7) s7 <= rxs;
      if (samp_idx == 4'd8) s8 <= rxs;
    end
  end

  // samples 7 and 8 are held; sample 9 is the live rxs at the deciding tick
  assign vote_bit = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (bit_clr)       bit_idx <= '0;
      else if (bit_inc)  bit_idx <= bit_idx + 3'd1;
      if (shift_en)      shreg   <= {vote_bit, shreg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_en, set_perr;

  always_ff @(posedge clk) begin
    if (rst)         par_bit <= 1'b0;
    else if (par_en) par_bit <= vote_bit;
  end

  // even parity over data plus parity bit must come out zero
  assign par_bad = ^{shreg, par_bit};
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr_timer  = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    shift_en   = 1'b0;
    push_req   = 1'b0;
    set_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en     = 1'b0;
    set_perr   = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_next = S_START;
          clr_timer  = 1'b1;
        end
      end
      S_START: begin
        if (tick && samp_idx == 4'd7 && rxs) begin
          state_next = S_IDLE;
        end else if (tick && samp_idx == 4'd15) begin
          state_next = S_DATA;
          bit_clr    = 1'b1;
        end
      end
      S_DATA: begin
        if (tick && samp_idx == 4'd9) shift_en = 1'b1;
        if (tick && samp_idx == 4'd15) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick && samp_idx == 4'd9) par_en = 1'b1;
        if (tick && samp_idx == 4'd15) begin
          set_perr   = par_bad;
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick && samp_idx == 4'd7) begin
          if (rxs) begin
            push_req   = ~par_bad;
            state_next = S_IDLE;
          end else begin
            set_ferr   = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  assign ready   = (count != '0);
  assign full    = (count == FULL_COUNT);
  assign pop     = rd_en & ready;
  // a pop in the same cycle frees the slot the new byte lands in
  assign do_push = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign data_out = ready ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= set_ferr | (frame_err & ~err_clr);
      overrun   <= drop     | (overrun   & ~err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= set_perr | (parity_err & ~err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-level model of the received byte stream and sticky flags,
// a per-cycle compare process, directed frames with literal expectations, then random frames.
module tb_uart_rx_fifo;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int BITC  = 16 * DIV;

  logic       clk;
  logic       rst, rx, rd_en, err_clr;
  logic [7:0] data_out;
  logic       ready, busy, frame_err, overrun, parity_err;
  logic [$clog2(DEPTH):0] count;

  uart_rx_fifo #(.SAMPLE_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .err_clr(err_clr),
    .data_out(data_out), .ready(ready), .busy(busy), .count(count),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic exp_ferr, exp_ovr, exp_perr;
  bit   chk_on = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model bytes/flags are booked at frame start, so the DUT may only lag the model.
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("count_le_model", count > exp_q.size(), 0);
      if (exp_q.size() == 0) check("ready_when_empty", ready, 0);
      if (ready && exp_q.size() > 0) check("head", data_out, exp_q[0]);
      check("ferr_implied", frame_err & ~exp_ferr, 0);
      check("ovr_implied",  overrun   & ~exp_ovr,  0);
      check("perr_implied", parity_err & ~exp_perr, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic pop_one(output logic [7:0] got);
    got   = data_out;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    step();
    err_clr  = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    exp_perr = 1'b0;
  endtask

  // stop_low>0 holds the stop bit low that many clk; noise_bit inverts one sample
  // of that frame bit; abort_bit>=0 pulses rst in the middle of that frame bit.
  task automatic send_frame(input logic [7:0] d, input int stop_low, input int noise_bit,
                            input int abort_bit, input bit par_flip);
    logic [10:0] bits;
    int nb;
    bits = '0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9] = (^d) ^ par_flip;
    nb = 10;
`else
    nb = 9;
`endif
    if (abort_bit < 0) begin
      if (par_flip) exp_perr = 1'b1;
      if (stop_low > 0) exp_ferr = 1'b1;
      if (!par_flip && stop_low == 0) begin
        if (exp_q.size() == DEPTH) exp_ovr = 1'b1;
        else exp_q.push_back(d);
      end
    end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < BITC; c++) begin
        if (b == abort_bit && c == 32) begin
          rx  = 1'b1;
          rst = 1'b1;
          exp_q.delete();
          exp_ferr = 1'b0;
          exp_ovr  = 1'b0;
          exp_perr = 1'b0;
          step();
          step();
          rst = 1'b0;
          return;
        end
        rx = (b == noise_bit && c >= 36 && c < 40) ? ~bits[b] : bits[b];
        step();
      end
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      repeat (stop_low) step();
    end
    rx = 1'b1;
    repeat (BITC) step();
  endtask

  task automatic settle(input string tag);
    check({tag, "_count"}, count, exp_q.size());
    check({tag, "_ferr"}, frame_err, exp_ferr);
    check({tag, "_ovr"}, overrun, exp_ovr);
    check({tag, "_perr"}, parity_err, exp_perr);
    check({tag, "_busy"}, busy, 0);
    if (exp_q.size() > 0) check({tag, "_head"}, data_out, exp_q[0]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got, want;
    logic [7:0] b2b [4];
    logic [7:0] fill[4];
    int nrd, gap, sl, nz;
    bit pf;
    b2b  = '{8'h77, 8'h00, 8'hFF, 8'hA5};
    fill = '{8'h11, 8'h22, 8'h33, 8'h44};
    rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b1;
    exp_ferr = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_data", data_out, 8'h00);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_perr", parity_err, 0);
    chk_on = 1;
    idle(20);

    send_frame(8'h25, 0, -1, -1, 0);
    idle(2);
    check("single_ready", ready, 1);
    check("single_data", data_out, 8'h25);
    check("single_busy", busy, 0);
    pop_one(got);
    check("single_pop", got, 8'h25);
    check("single_ready_after", ready, 0);
    check("single_count_after", count, 0);

    for (int i = 0; i < 4; i++) send_frame(b2b[i], 0, -1, -1, 0);
    idle(2);
    check("b2b_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      pop_one(got);
      check("b2b_order", got, b2b[i]);
    end
    check("b2b_ferr", frame_err, 0);
    check("b2b_ovr", overrun, 0);

    for (int i = 0; i < 4; i++) send_frame(fill[i], 0, -1, -1, 0);
    send_frame(8'h3C, 0, -1, -1, 0);
    idle(2);
    check("ovr_flag", overrun, 1);
    check("ovr_count", count, 4);
    check("ovr_head", data_out, 8'h11);
    clr_err();
    check("ovr_cleared", overrun, 0);
    for (int i = 0; i < 4; i++) begin
      pop_one(got);
      check("ovr_drain", got, fill[i]);
    end

    rx = 1'b0;
    repeat (10) step();
    check("glitch_busy", busy, 1);
    repeat (10) step();
    idle(100);
    check("glitch_busy_after", busy, 0);
    check("glitch_count", count, 0);
    check("glitch_ferr", frame_err, 0);

    send_frame(8'h5A, 0, 4, -1, 0);
    idle(2);
    check("noise_data", data_out, 8'h5A);
    check("noise_count", count, 1);
    pop_one(got);

    send_frame(8'h81, 200, -1, -1, 0);
    idle(20);
    check("frame_ferr", frame_err, 1);
    check("frame_count", count, 0);
    send_frame(8'h42, 0, -1, -1, 0);
    idle(2);
    check("frame_next_data", data_out, 8'h42);
    check("frame_sticky", frame_err, 1);

    send_frame(8'h66, 0, -1, -1, 0);
    send_frame(8'hC3, 0, -1, 5, 0);
    idle(10);
    check("abort_count", count, 0);
    check("abort_ready", ready, 0);
    check("abort_busy", busy, 0);
    check("abort_data", data_out, 8'h00);
    check("abort_ferr", frame_err, 0);
    send_frame(8'h19, 0, -1, -1, 0);
    idle(2);
    check("abort_next_data", data_out, 8'h19);
    check("abort_next_count", count, 1);
    pop_one(got);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h25, 0, -1, -1, 0);
    idle(2);
    check("par_good_data", data_out, 8'h25);
    check("par_good_perr", parity_err, 0);
    pop_one(got);
    send_frame(8'h25, 0, -1, -1, 1);
    idle(2);
    check("par_bad_perr", parity_err, 1);
    check("par_bad_count", count, 0);
    clr_err();
`endif

    for (int it = 0; it < 20; it++) begin
      nrd = $urandom_range(0, exp_q.size());
      for (int r = 0; r < nrd; r++) begin
        want = exp_q[0];
        pop_one(got);
        check("rand_pop", got, want);
      end
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 80);
      idle(gap);
      sl = ($urandom_range(0, 5) == 0) ? $urandom_range(100, 200) : 0;
      nz = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : -1;
`ifdef UART_RX_PARITY_EN
      pf = ($urandom_range(0, 4) == 0);
`else
      pf = 1'b0;
`endif
      send_frame(8'($urandom), sl, nz, -1, pf);
      idle(2);
      settle("rand");
      if ($urandom_range(0, 3) == 0) clr_err();
    end

    while (exp_q.size() > 0) begin
      want = exp_q[0];
      pop_one(got);
      check("final_drain", got, want);
    end
    idle(2);
    check("final_count", count, 0);

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
